// File: rtl/imem_loadable_pkg.sv
// Shared types and defaults for the loadable instruction memory.
// Holds the fault codes, FSM state encoding and default bus widths.
package imem_loadable_pkg;

    localparam int DEF_INSTR_W = 16;
    localparam int DEF_ADDR_W  = 8;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

endpackage

// File: rtl/imem_loadable_if.sv
// Load-stream and fetch bus of the instruction memory.
// master = loader/fetch stage side, slave = memory side.
interface imem_loadable_if
    import imem_loadable_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int ADDR_W  = DEF_ADDR_W
);
    logic               load_start;
    logic               load_valid;
    logic [INSTR_W-1:0] load_data;
    logic               load_last;
    logic               load_ready;
    logic               load_done;
    logic               load_err;

    logic               fetch_req;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               fetch_ready;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [1:0]         fault;

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        input  load_ready, load_done, load_err, fetch_ready, instr, instr_valid, fault
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        output load_ready, load_done, load_err, fetch_ready, instr, instr_valid, fault
    );

endinterface

// File: rtl/imem_loadable_sp_ram.sv
// Simple-dual-access word RAM: synchronous write, registered read.
// The read register only updates on i_re so it holds the last fetched word.
module imem_sp_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 28,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: RUN/LOAD FSM, write pointer, fetch decode and faults.
// Program words stream in during LOAD; fetch returns one instruction per cycle in RUN.
module imem_loadable
    import imem_loadable_pkg::*;
#(
    parameter int                 INSTR_W  = DEF_INSTR_W,
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 DEPTH    = 28,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
    input  logic            clk,
    input  logic            rst,
    imem_loadable_if.slave  bus
);

    localparam int                RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                WPTR_W    = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] DEPTH_IDX = ADDR_W'(DEPTH);
    localparam logic [WPTR_W-1:0] DEPTH_PTR = WPTR_W'(DEPTH);

    state_e              r_state;
    state_e              w_state_next;
    logic [WPTR_W-1:0]   r_wptr;
    logic [WPTR_W-1:0]   w_wptr_next;
    logic                r_load_err;
    logic                w_load_err_next;
    logic                r_load_done;
    logic                w_load_done_next;
    logic                w_we;

    logic                r_instr_valid;
    fault_e              r_fault;
    fault_e              w_fault;
    logic                r_use_ram;

    logic                w_fetch_ready;
    logic                w_fetch_acc;
    logic                w_re;
    logic                w_room;
    logic [ADDR_W-2:0]   w_widx;
    logic [INSTR_W-1:0]  w_ram_rdata;

    // load_start wins over a fetch in the same cycle
    assign w_fetch_ready = (r_state == ST_RUN) && !bus.load_start;
    assign w_fetch_acc   = bus.fetch_req && w_fetch_ready;
    assign w_widx        = bus.fetch_addr[ADDR_W-1:1];
    assign w_room        = (r_wptr < DEPTH_PTR);

    always_comb begin
        w_fault = FAULT_OK;
        if (bus.fetch_addr[0]) begin
            w_fault = FAULT_MISALIGN;
        end else if ({1'b0, w_widx} >= DEPTH_IDX) begin
            w_fault = FAULT_RANGE;
        end
    end

    assign w_re = w_fetch_acc && (w_fault == FAULT_OK);

    always_comb begin
        w_state_next     = r_state;
        w_wptr_next      = r_wptr;
        w_load_err_next  = r_load_err;
        w_load_done_next = 1'b0;
        w_we             = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.load_start) begin
                    w_state_next    = ST_LOAD;
                    w_wptr_next     = '0;
                    w_load_err_next = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.load_start) begin
                    w_wptr_next     = '0;
                    w_load_err_next = 1'b0;
                end else if (bus.load_valid) begin
                    if (w_room) begin
                        w_we        = 1'b1;
                        w_wptr_next = r_wptr + WPTR_W'(1);
                    end else begin
                        w_load_err_next = 1'b1;
                    end
                    if (bus.load_last) begin
                        w_state_next     = ST_RUN;
                        w_load_done_next = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_wptr      <= '0;
            r_load_err  <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wptr      <= w_wptr_next;
            r_load_err  <= w_load_err_next;
            r_load_done <= w_load_done_next;
        end
    end

    // fault/source only move on an accepted fetch, so instr holds otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr_valid <= 1'b0;
            r_fault       <= FAULT_OK;
            r_use_ram     <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch_acc;
            if (w_fetch_acc) begin
                r_fault   <= w_fault;
                r_use_ram <= (w_fault == FAULT_OK);
            end
        end
    end

    imem_sp_ram #(
        .DATA_W (INSTR_W),
        .DEPTH  (DEPTH),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we && rst),
        .i_waddr (r_wptr[RAM_AW-1:0]),
        .i_wdata (bus.load_data),
        .i_re    (w_re && rst),
        .i_raddr (w_widx[RAM_AW-1:0]),
        .o_rdata (w_ram_rdata)
    );

    assign bus.load_ready  = (r_state == ST_LOAD);
    assign bus.load_done   = r_load_done;
    assign bus.load_err    = r_load_err;
    assign bus.fetch_ready = w_fetch_ready;
    assign bus.instr       = r_use_ram ? w_ram_rdata : NOP_WORD;
    assign bus.instr_valid = r_instr_valid;
    assign bus.fault       = r_fault;

endmodule

// File: tb/tb_imem_loadable.sv
// Randomised bench for imem_loadable against an array/queue model of the program memory.
// Directed scenarios first, then random loads, fetches and resets.
`timescale 1ns/1ps
module tb_imem_loadable;

    localparam int          IW    = 16;
    localparam int          AW    = 8;
    localparam int          DEPTH = 28;
    localparam logic [15:0] NOP   = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_loadable_if #(.INSTR_W(IW), .ADDR_W(AW)) bus();

    imem_loadable #(
        .INSTR_W  (IW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // reference model: program memory plus loader/fetch observable state
    logic [15:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];
    bit          ref_load;
    int          ref_wptr;
    bit          ref_err;
    logic [15:0] ref_instr;
    bit          ref_instr_known;
    logic [1:0]  ref_fault;
    bit          exp_valid;
    bit          exp_done;
    int          last_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_data  = '0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
    endtask

    // one clock: check handshake levels, advance model, check registered outputs
    task automatic step();
        int fa;
        #1;
        if (rst) begin
            check("load_ready", 32'(bus.load_ready), 32'(ref_load));
            check("fetch_ready", 32'(bus.fetch_ready), 32'(!ref_load && !bus.load_start));
        end
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (!rst) begin
            ref_load        = 1'b0;
            ref_wptr        = 0;
            ref_err         = 1'b0;
            ref_instr       = NOP;
            ref_instr_known = 1'b1;
            ref_fault       = 2'b00;
        end else begin
            if (!ref_load && !bus.load_start && bus.fetch_req) begin
                fa        = int'(bus.fetch_addr);
                exp_valid = 1'b1;
                last_addr = fa;
                if (fa % 2 != 0) begin
                    ref_fault = 2'b01; ref_instr = NOP; ref_instr_known = 1'b1;
                end else if (fa / 2 >= DEPTH) begin
                    ref_fault = 2'b10; ref_instr = NOP; ref_instr_known = 1'b1;
                end else begin
                    ref_fault       = 2'b00;
                    ref_instr       = ref_mem[fa / 2];
                    ref_instr_known = ref_known[fa / 2];
                end
            end
            if (bus.load_start) begin
                ref_load = 1'b1; ref_wptr = 0; ref_err = 1'b0;
            end else if (ref_load && bus.load_valid) begin
                if (ref_wptr < DEPTH) begin
                    ref_mem[ref_wptr]   = bus.load_data;
                    ref_known[ref_wptr] = 1'b1;
                    ref_wptr++;
                end else begin
                    ref_err = 1'b1;
                end
                if (bus.load_last) begin
                    ref_load = 1'b0; exp_done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
        check("fault", 32'(bus.fault), 32'(ref_fault));
        if (ref_instr_known) check("instr", 32'(bus.instr), 32'(ref_instr));
        check("load_done", 32'(bus.load_done), 32'(exp_done));
        check("load_err", 32'(bus.load_err), 32'(ref_err));
        if (exp_valid)
            $display("fetch addr=%02h instr=%04h fault=%0d", last_addr, bus.instr, bus.fault);
        if (exp_done)
            $display("load done words=%0d err=%0b", ref_wptr, bus.load_err);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        step();
        step();
        rst = 1'b1;
    endtask

    // optional gap cycles carry a refused fetch and an unqualified load_last
    task automatic load_words(input logic [15:0] w[$], input bit gaps, input bit finish);
        idle();
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        foreach (w[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.load_valid = 1'b0;
                    bus.load_last  = 1'($urandom_range(0, 1));
                    bus.fetch_req  = 1'($urandom_range(0, 1));
                    bus.fetch_addr = 8'($urandom);
                    step();
                end
                bus.fetch_req = 1'b0;
            end
            bus.load_valid = 1'b1;
            bus.load_data  = w[i];
            bus.load_last  = finish && (i == w.size() - 1);
            step();
        end
        idle();
    endtask

    task automatic fetch(input logic [7:0] a);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q[$];
        int          n;
        int          op;
        logic [7:0]  a;

        idle();
        do_reset();
        check("rst_instr", 32'(bus.instr), 32'(NOP));
        check("rst_valid", 32'(bus.instr_valid), 32'd0);

        // 1: short program, back-to-back fetches
        q = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        load_words(q, 1'b0, 1'b1);
        check("t1_done", 32'(bus.load_done), 32'd1);
        fetch(8'h00);
        check("t1_i0", 32'(bus.instr), 32'h0000_A001);
        fetch(8'h02);
        fetch(8'h04);
        fetch(8'h06);
        check("t1_i3", 32'(bus.instr), 32'h0000_A004);
        idle();
        step();

        // 2: misaligned, out of range, both
        fetch(8'h03);
        check("t2_mis", 32'(bus.fault), 32'd1);
        check("t2_nop", 32'(bus.instr), 32'(NOP));
        fetch(8'h38);
        check("t2_rng", 32'(bus.fault), 32'd2);
        fetch(8'h39);
        check("t2_prio", 32'(bus.fault), 32'd1);
        idle();
        step();

        // 3: overflow load
        q.delete();
        for (int i = 0; i < 29; i++) q.push_back(16'h3000 + 16'(i));
        load_words(q, 1'b0, 1'b1);
        check("t3_err", 32'(bus.load_err), 32'd1);
        fetch(8'd54);
        check("t3_last", 32'(bus.instr), 32'h0000_301B);
        idle();
        step();

        // 4: fetch colliding with load_start
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h00;
        bus.load_start = 1'b1;
        step();
        check("t4_novalid", 32'(bus.instr_valid), 32'd0);
        bus.load_start = 1'b0;
        step();
        step();
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h4444;
        bus.load_last  = 1'b1;
        step();
        check("t4_done", 32'(bus.load_done), 32'd1);
        check("t4_errclr", 32'(bus.load_err), 32'd0);
        idle();
        fetch(8'h00);
        check("t4_i0", 32'(bus.instr), 32'h0000_4444);
        idle();

        // 5: reset during a load
        q = '{16'h5500, 16'h5501, 16'h5502};
        load_words(q, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("t5_run", 32'(bus.load_ready), 32'd0);
        fetch(8'h02);
        check("t5_w1", 32'(bus.instr), 32'h0000_5501);
        idle();

        // 6: restart mid-load
        q = '{16'h6600, 16'h6601};
        load_words(q, 1'b0, 1'b0);
        q = '{16'h6602};
        load_words(q, 1'b0, 1'b1);
        check("t6_done", 32'(bus.load_done), 32'd1);
        fetch(8'h00);
        check("t6_w0", 32'(bus.instr), 32'h0000_6602);
        fetch(8'h02);
        check("t6_w1", 32'(bus.instr), 32'h0000_6601);
        idle();
        step();

        // random phase
        for (int it = 0; it < 200; it++) begin
            op = $urandom_range(0, 19);
            if (op < 5) begin
                n = $urandom_range(1, 31);
                q.delete();
                for (int i = 0; i < n; i++) q.push_back(16'($urandom));
                load_words(q, 1'b1, op != 0);
                if (op == 0) do_reset();
            end else if (op < 19) begin
                repeat ($urandom_range(1, 8)) begin
                    case ($urandom_range(0, 3))
                        0:       a = 8'($urandom);
                        1:       a = 8'(2 * $urandom_range(DEPTH, 127));
                        default: a = 8'(2 * $urandom_range(0, DEPTH - 1));
                    endcase
                    bus.fetch_req  = 1'($urandom_range(0, 3) != 0);
                    bus.fetch_addr = a;
                    step();
                end
                idle();
            end else begin
                do_reset();
            end
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
